// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults and instruction-queue entry type for the fetch unit
package fetch_pkg;

   localparam int          XLEN_DEFAULT     = 32;
   localparam int          INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [INSTR_W-1:0]      instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - redirect, instruction-memory and decode handshakes of the fetch unit
interface fetch_if import fetch_pkg::*; #(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int DEPTH = 4
) ();

   localparam int OW = $clog2(DEPTH) + 1;

   logic               redirect_valid;
   logic [XLEN-1:0]    redirect_pc;
   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [XLEN-1:0]    imem_req_addr;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               dec_valid;
   logic               dec_ready;
   logic [XLEN-1:0]    dec_pc;
   logic [INSTR_W-1:0] dec_instr;
   logic [OW-1:0]      occupancy;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
      output imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, occupancy
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
      input  imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, occupancy
   );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction queue with clear; power-of-two depth
module fetch_fifo import fetch_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int WIDTH = $bits(fetch_entry_t)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       head_data_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop, full;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_push = push_i & ~clear_i;
   assign do_pop  = pop_i & ~clear_i & (count_q != '0);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   // The fetch credit scheme makes this unreachable; a hit means a credit bug, not backpressure.
   overflow_a: assert property (@(posedge clk) disable iff (rst) !(do_push && full));

   assign head_data_o = mem_q[rd_ptr_q];
   assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-limited instruction fetch with redirect flush and response discard
module fetch_unit import fetch_pkg::*; #(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input logic     clk,
   input logic     rst,
   fetch_if.master bus
);

   localparam int OW = $clog2(DEPTH) + 1;
   localparam int EW = XLEN + INSTR_W;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redirect_tgt;
   logic [OW-1:0]   outstanding_q, outstanding_d, discard_q, discard_d, occupancy;
   logic [OW:0]     credit_used;
   logic [EW-1:0]   head;
   logic            req_valid, req_fire, rsp_acc, push, dec_valid, dec_fire;
   logic            unused_redirect_lsbs;

   assign redirect_tgt         = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

   assign dec_valid = (occupancy != '0) & ~bus.redirect_valid & ~rst;
   assign dec_fire  = dec_valid & bus.dec_ready;

   // Every issued request must have a guaranteed queue slot, counting the entry decode frees now.
   assign credit_used = {1'b0, occupancy} + {1'b0, outstanding_q} - (OW+1)'(dec_fire);
   assign req_valid   = ~rst & ~bus.redirect_valid & (credit_used < (OW+1)'(DEPTH));
   assign req_fire    = req_valid & bus.imem_req_ready;
   assign rsp_acc     = bus.imem_rsp_valid & ~rst;
   assign push        = rsp_acc & (discard_q == '0) & ~bus.redirect_valid;

   always_comb begin
      outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_acc);
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      discard_d     = discard_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = redirect_tgt;
         rsp_pc_d   = redirect_tgt;
         discard_d  = outstanding_q - OW'(rsp_acc);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (push)     rsp_pc_d   = rsp_pc_q + XLEN'(4);
         if (rsp_acc && (discard_q != '0)) discard_d = discard_q - OW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (bus.redirect_valid),
      .push_i      (push),
      .push_data_i ({rsp_pc_q, bus.imem_rsp_data}),
      .pop_i       (dec_fire),
      .head_data_o (head),
      .count_o     (occupancy)
   );

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.dec_valid      = dec_valid;
   assign bus.dec_pc         = head[EW-1:INSTR_W];
   assign bus.dec_instr      = head[INSTR_W-1:0];
   assign bus.occupancy      = occupancy;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized memory model and queue scoreboard for fetch_unit
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam int          OW       = $clog2(DEPTH) + 1;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef logic [OW-1:0] occ_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

   fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int          p_req_ready, p_dec_ready, lat_lo, lat_hi, last_due, m_disc;
   logic        redir_now;
   logic [31:0] redir_pc;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   fetch_entry_t m_q[$];
   logic [31:0] m_fetch_pc, m_rsp_pc;

   logic        s_req_valid, s_dec_valid;
   logic [31:0] s_addr, s_dec_pc, s_dec_instr;
   occ_t        s_occ;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h0019_660D) ^ 32'h1357_9BDF;
   endfunction

   // One clock: drive memory/decode inputs, check against the queue model, then advance it.
   task automatic step();
      logic         rsp_v, exp_dv, exp_rv, dfire, fire_req;
      logic [31:0]  rsp_addr;
      int           lat, used, due;
      fetch_entry_t ent;
      rsp_v    = 1'b0;
      rsp_addr = '0;
      exp_dv   = 1'b0;
      dfire    = 1'b0;
      if (rst) rsp_v = 1'b1;
      else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         rsp_v    = 1'b1;
         rsp_addr = pend_addr[0];
      end
      bus.imem_rsp_valid = rsp_v;
      bus.imem_rsp_data  = rst ? 32'hBAD0_BAD0 : instr_of(rsp_addr);
      bus.imem_req_ready = (int'($urandom_range(99)) < p_req_ready);
      bus.dec_ready      = (int'($urandom_range(99)) < p_dec_ready);
      bus.redirect_valid = redir_now;
      bus.redirect_pc    = redir_pc;
      #1;
      s_req_valid = bus.imem_req_valid;
      s_addr      = bus.imem_req_addr;
      s_dec_valid = bus.dec_valid;
      s_dec_pc    = bus.dec_pc;
      s_dec_instr = bus.dec_instr;
      s_occ       = bus.occupancy;
      if (rst) begin
         total++;
         if (s_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", s_req_valid); end
         total++;
         if (s_dec_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_valid: got %b want 0", s_dec_valid); end
         total++;
         if (s_occ !== '0) begin bad++; $display("FAIL rst_occupancy: got %0d want 0", s_occ); end
      end else begin
         exp_dv = (m_q.size() != 0) && !redir_now;
         dfire  = exp_dv && bus.dec_ready;
         used   = m_q.size() + pend_addr.size() - (dfire ? 1 : 0);
         exp_rv = !redir_now && (used < DEPTH);
         total++;
         if (s_occ !== occ_t'(m_q.size()))
            begin bad++; $display("FAIL occupancy @%0d: got %0d want %0d", cyc, s_occ, m_q.size()); end
         total++;
         if (s_dec_valid !== exp_dv)
            begin bad++; $display("FAIL dec_valid @%0d: got %b want %b", cyc, s_dec_valid, exp_dv); end
         if (exp_dv) begin
            total++;
            if (s_dec_pc !== m_q[0].pc || s_dec_instr !== m_q[0].instr) begin
               bad++;
               $display("FAIL dec_head @%0d: got pc=%h instr=%h want pc=%h instr=%h",
                        cyc, s_dec_pc, s_dec_instr, m_q[0].pc, m_q[0].instr);
            end
         end
         total++;
         if (s_req_valid !== exp_rv)
            begin bad++; $display("FAIL req_valid @%0d: got %b want %b", cyc, s_req_valid, exp_rv); end
         if (exp_rv) begin
            total++;
            if (s_addr !== m_fetch_pc)
               begin bad++; $display("FAIL req_addr @%0d: got %h want %h", cyc, s_addr, m_fetch_pc); end
         end
      end
      fire_req = (s_req_valid === 1'b1) && bus.imem_req_ready;
      @(posedge clk);
      if (rst) begin
         pend_addr.delete();
         pend_due.delete();
         m_q.delete();
         m_fetch_pc = RESET_PC;
         m_rsp_pc   = RESET_PC;
         m_disc     = 0;
         last_due   = cyc;
      end else begin
         if (rsp_v) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
         if (redir_now) begin
            m_q.delete();
            m_disc     = pend_addr.size();
            m_fetch_pc = redir_pc & ~32'h3;
            m_rsp_pc   = redir_pc & ~32'h3;
         end else begin
            if (dfire) void'(m_q.pop_front());
            if (rsp_v) begin
               if (m_disc > 0) m_disc--;
               else begin
                  ent.pc    = m_rsp_pc;
                  ent.instr = instr_of(rsp_addr);
                  m_q.push_back(ent);
                  m_rsp_pc += 32'd4;
                  total++;
                  if (m_q.size() > DEPTH)
                     begin bad++; $display("FAIL overflow @%0d: queue %0d entries, limit %0d", cyc, m_q.size(), DEPTH); end
               end
            end
         end
         if (fire_req) begin
            lat = int'($urandom_range(lat_hi, lat_lo));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(s_addr);
            pend_due.push_back(due);
            if (!redir_now) m_fetch_pc += 32'd4;
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      rst                = 1'b1;
      redir_now          = 1'b0;
      redir_pc           = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.dec_ready      = 1'b0;
      @(negedge clk);
      cyc++;
      repeat (3) step();
      rst = 1'b0;
   endtask

   task automatic test_stream();
      lat_lo = 1; lat_hi = 1; p_req_ready = 100; p_dec_ready = 100;
      test_reset();
      step();
      total++;
      if (s_req_valid !== 1'b1 || s_addr !== RESET_PC)
         begin bad++; $display("FAIL first_req: got valid=%b addr=%h want 1/%h", s_req_valid, s_addr, RESET_PC); end
      step();
      step();
      total++;
      if (s_dec_valid !== 1'b1 || s_dec_pc !== RESET_PC)
         begin bad++; $display("FAIL first_dec: got valid=%b pc=%h want 1/%h", s_dec_valid, s_dec_pc, RESET_PC); end
      for (int k = 1; k <= 12; k++) begin
         step();
         total++;
         if (s_dec_valid !== 1'b1 || s_dec_pc !== RESET_PC + 32'(4 * k))
            begin bad++; $display("FAIL stream %0d: got valid=%b pc=%h want 1/%h", k, s_dec_valid, s_dec_pc, RESET_PC + 32'(4 * k)); end
      end
   endtask

   task automatic test_stall();
      logic [31:0] held_pc, held_instr;
      p_dec_ready = 0;
      step();
      held_pc    = s_dec_pc;
      held_instr = s_dec_instr;
      repeat (9) begin
         step();
         total++;
         if (s_dec_valid !== 1'b1 || s_dec_pc !== held_pc || s_dec_instr !== held_instr)
            begin bad++; $display("FAIL stall_hold: got pc=%h instr=%h want %h/%h", s_dec_pc, s_dec_instr, held_pc, held_instr); end
      end
      total++;
      if (s_occ !== occ_t'(DEPTH)) begin bad++; $display("FAIL stall_occ: got %0d want %0d", s_occ, DEPTH); end
      total++;
      if (s_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", s_req_valid); end
      p_dec_ready = 100;
      for (int k = 0; k < 10; k++) begin
         step();
         total++;
         if (s_dec_valid !== 1'b1 || s_dec_pc !== held_pc + 32'(4 * k))
            begin bad++; $display("FAIL drain %0d: got pc=%h want %h", k, s_dec_pc, held_pc + 32'(4 * k)); end
      end
   endtask

   task automatic test_redirect_outstanding();
      bit first_seen;
      lat_lo = 3; lat_hi = 3; p_req_ready = 100; p_dec_ready = 100;
      test_reset();
      step();
      step();
      p_req_ready = 0;
      redir_now = 1'b1; redir_pc = 32'h100;
      step();
      redir_now = 1'b0;
      p_req_ready = 100;
      total++;
      if (s_dec_valid !== 1'b0 || s_req_valid !== 1'b0)
         begin bad++; $display("FAIL redirect_gate: got dec=%b req=%b want 0/0", s_dec_valid, s_req_valid); end
      step();
      total++;
      if (s_req_valid !== 1'b1 || s_addr !== 32'h100)
         begin bad++; $display("FAIL redirect_addr: got valid=%b addr=%h want 1/100", s_req_valid, s_addr); end
      first_seen = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (s_dec_valid === 1'b1) begin
            if (!first_seen) begin
               total++;
               if (s_dec_pc !== 32'h100) begin bad++; $display("FAIL redirect_first: got %h want 100", s_dec_pc); end
               first_seen = 1;
            end
            total++;
            if (s_dec_pc < 32'h100) begin bad++; $display("FAIL stale_pc: got %h want >= 100", s_dec_pc); end
         end
      end
      total++;
      if (!first_seen) begin bad++; $display("FAIL redirect_timeout: got no dec_valid want one within 15 cycles"); end
   endtask

   task automatic test_back_to_back();
      bit first_seen;
      lat_lo = 3; lat_hi = 3; p_req_ready = 100; p_dec_ready = 100;
      test_reset();
      step();
      step();
      redir_now = 1'b1; redir_pc = 32'h100;
      step();
      redir_pc = 32'h300;
      step();
      redir_now = 1'b0;
      first_seen = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (s_dec_valid === 1'b1 && !first_seen) begin
            total++;
            if (s_dec_pc !== 32'h300) begin bad++; $display("FAIL b2b_first: got %h want 300", s_dec_pc); end
            first_seen = 1;
         end
      end
      total++;
      if (!first_seen) begin bad++; $display("FAIL b2b_timeout: got no dec_valid want one within 15 cycles"); end
   endtask

   task automatic test_redirect_with_rsp();
      bit first_seen;
      lat_lo = 2; lat_hi = 2; p_req_ready = 100; p_dec_ready = 100;
      test_reset();
      repeat (6) step();
      redir_now = 1'b1; redir_pc = 32'h203;
      step();
      redir_now = 1'b0;
      step();
      total++;
      if (s_req_valid !== 1'b1 || s_addr !== 32'h200)
         begin bad++; $display("FAIL redirect_align: got valid=%b addr=%h want 1/200", s_req_valid, s_addr); end
      first_seen = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (s_dec_valid === 1'b1 && !first_seen) begin
            total++;
            if (s_dec_pc !== 32'h200) begin bad++; $display("FAIL rsp_redirect_first: got %h want 200", s_dec_pc); end
            first_seen = 1;
         end
      end
      total++;
      if (!first_seen) begin bad++; $display("FAIL rsp_redirect_timeout: got no dec_valid want one within 10 cycles"); end
   endtask

   task automatic test_random();
      lat_lo = 1; lat_hi = 4; p_req_ready = 60; p_dec_ready = 70;
      test_reset();
      for (int i = 0; i < 3000; i++) begin
         redir_now = (int'($urandom_range(99)) < 3);
         redir_pc  = $urandom;
         step();
         total++;
         if (s_occ > occ_t'(DEPTH)) begin bad++; $display("FAIL occ_bound @%0d: got %0d want <= %0d", cyc, s_occ, DEPTH); end
      end
      redir_now = 1'b0;
      repeat (20) step();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_outstanding();
      test_back_to_back();
      test_redirect_with_rsp();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter DEPTH, default 4, instruction queue entries; power of 2, >=2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 redirect_valid  in  1  branch/jump redirect from execute; flushes the unit.
REQ-007 redirect_pc  in  XLEN  redirect target; bits [1:0] ignored, treated as 00.
REQ-008 imem_req_valid  out  1  fetch request valid.
REQ-009 imem_req_ready  in  1  memory accepts request.
REQ-010 imem_req_addr  out  XLEN  fetch address, word aligned.
REQ-011 imem_rsp_valid  in  1  instruction word returned; responses in request order, latency >=1 cycle.
REQ-012 imem_rsp_data  in  32  returned instruction.
REQ-013 dec_valid  out  1  queue head valid toward decode.
REQ-014 dec_ready  in  1  decode accepts (inverse of decode stall).
REQ-015 dec_pc  out  XLEN  PC of head instruction.
REQ-016 dec_instr  out  32  head instruction.
REQ-017 occupancy  out  clog2(DEPTH)+1  current queue entry count.

Function
REQ-018 Request fire = imem_req_valid & imem_req_ready; on fire fetch PC advances by 4 (wraps modulo 2^XLEN).
REQ-019 imem_req_valid = !rst & !redirect_valid & (occupancy + outstanding - dec_fire < DEPTH); dec_fire = dec_valid & dec_ready.
REQ-020 outstanding counter (0..DEPTH): +1 on request fire, -1 on accepted response, both same cycle = unchanged.
REQ-021 Response PC register starts at RESET_PC or redirect target, +4 per response enqueued; entry stores {pc, instr}.
REQ-022 Accepted response with discard count 0 is pushed to queue tail; push and pop in same cycle both take effect.
REQ-023 Credit rule (REQ-019) guarantees no overflow; a push to a full queue is an assertion failure, never silently dropped.
REQ-024 dec_valid = (occupancy != 0) & !redirect_valid; dec_pc/dec_instr come from the queue head and are stable while dec_valid & !dec_ready.
REQ-025 Latency: request fired at cycle t with response at t+L yields dec_valid at t+L+1 at the earliest; no response-to-decode bypass.
REQ-026 Throughput: with L=1, DEPTH=2 and dec_ready held high, one instruction per cycle is sustained.
REQ-027 Redirect cycle: queue cleared, fetch PC and response PC <= {redirect_pc[XLEN-1:2],2'b00}, discard count <= outstanding - rsp_accepted_this_cycle, outstanding retained.
REQ-028 While discard count >0, each response is dropped and decrements both discard count and outstanding.
REQ-029 Back-to-back redirects: the later one wins; discard count is recomputed per REQ-027.
REQ-030 Redirect has priority over dec_ready, push and request issue in the same cycle.

Reset
REQ-031 During rst: imem_req_valid=0, dec_valid=0, occupancy=0, outstanding=0, discard count=0, fetch PC=response PC=RESET_PC.
REQ-032 Responses arriving during rst are ignored, and memory is not expected to return responses for requests accepted before reset.
REQ-033 First request issues in the first cycle after rst deasserts, with addr=RESET_PC.

Structure
REQ-034 Shared package fetch_pkg holds XLEN default, RESET_PC default and the queue-entry struct {pc, instr}.
REQ-035 Sub-module fetch_fifo (synchronous FIFO, parameter DEPTH, sync clear input) implements the queue, and fetch_unit holds the PC, credit and discard logic.

Verification
REQ-036 Reset release, L=1, dec_ready=1 -> addresses 0,4,8,...; dec_pc 0 at cycle 2 after release, then +4 every cycle, instr matches memory.
REQ-037 dec_ready=0 for 10 cycles, DEPTH=4 -> occupancy saturates at 4, imem_req_valid drops, dec_pc/instr held; release -> drains in order with no loss or duplicates.
REQ-038 L=3, two requests outstanding, redirect_pc=0x100 -> next two responses dropped; first dec_pc=0x100; no stale PC ever reaches decode.
REQ-039 Redirect in the same cycle as a response -> discard count = outstanding-1; following instruction stream starts at target.
REQ-040 redirect_pc=0x203 -> imem_req_addr=0x200.
REQ-041 imem_req_ready toggled randomly, with random L from 1 to 4 and random dec_ready -> scoreboard shows in-order PCs, occupancy <= DEPTH and no overflow assertion.
